// File: rtl/uart_rx_os.sv
// uart_rx_os: oversampling UART receiver with 2-of-3 majority voting,
// optional parity, 1..2 stop bits and a valid/ready output hold.
// Ports: clk, reset (sync, active-high), enable, rxd (async line),
//   data/valid/ready handshake, parity_err, frame_err, overrun, busy.
module uart_rx_os #(
  parameter int BAUD_RATE  = 9600,
  parameter int CLOCK_HZ   = 50_000_000,
  parameter int N_BITS     = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY     = 0,
  parameter int OVERSAMPLE = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              rxd,
  output logic [N_BITS-1:0] data,
  output logic              valid,
  input  logic              ready,
  output logic              parity_err,
  output logic              frame_err,
  output logic              overrun,
  output logic              busy
);

  localparam int DIV   = CLOCK_HZ / (BAUD_RATE * OVERSAMPLE);
  localparam int DIV_C = (DIV < 1) ? 1 : DIV;
  localparam int DW    = (DIV_C > 1) ? $clog2(DIV_C) : 1;
  localparam int TW    = $clog2(OVERSAMPLE);
  localparam int BW    = $clog2(N_BITS + 1);

  localparam logic [DW-1:0] DIV_LAST  = DW'(DIV_C - 1);
  localparam logic [TW-1:0] T_A       = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] T_B       = TW'(OVERSAMPLE / 2);
  localparam logic [TW-1:0] T_C       = TW'(OVERSAMPLE / 2 + 1);
  localparam logic [TW-1:0] T_END     = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(N_BITS - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP
  } state_t;

  state_t state, state_n;

  logic              sync1, sync2, rx_prev;
  logic              rx, rx_fall, start_det;
  logic [DW-1:0]     div_cnt;
  logic [TW-1:0]     tick_cnt;
  logic [BW-1:0]     bit_cnt;
  logic              tick, at_c, at_end;
  logic              samp_a, samp_b, maj;
  logic [N_BITS-1:0] shreg;
  logic              pe_pend, fe_pend;
  logic              par_bad, pe_final, fe_final;
  logic              done, load;

  assign rx = sync2;
  // rx_prev only tracks the line, so a frame ending on a low line
  // cannot re-trigger until the line has been high for a cycle.
  assign rx_fall   = rx_prev & ~rx;
  assign start_det = (state == S_IDLE) & enable & rx_fall;

  assign tick   = (div_cnt == DIV_LAST);
  assign at_c   = tick & (tick_cnt == T_C);
  assign at_end = tick & (tick_cnt == T_END);

  // Third sample is the live line value at the decision tick.
  assign maj = (samp_a & samp_b) | (samp_a & rx) | (samp_b & rx);

  assign par_bad  = (PARITY == 1) ? ~(^shreg ^ maj) : (^shreg ^ maj);
  assign pe_final = (PARITY == 0) ? 1'b0 : pe_pend;
  assign fe_final = fe_pend | ~maj;

  assign load = done & (~valid | ready);
  assign busy = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1   <= 1'b1;
      sync2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      sync1   <= rxd;
      sync2   <= sync1;
      rx_prev <= sync2;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    done    = 1'b0;
    if (!enable) begin
      state_n = S_IDLE;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (rx_fall) state_n = S_START;
        end
        S_START: begin
          if (at_c && maj) state_n = S_IDLE;
          else if (at_end) state_n = S_DATA;
        end
        S_DATA: begin
          if (at_end && bit_cnt == LAST_BIT)
            state_n = (PARITY != 0) ? S_PAR : S_STOP;
        end
        S_PAR: begin
          if (at_end) state_n = S_STOP;
        end
        S_STOP: begin
          // Complete at the centre of the last stop bit.
          if (at_c && bit_cnt == LAST_STOP) begin
            state_n = S_IDLE;
            done    = 1'b1;
          end
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt  <= '0;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      samp_a   <= 1'b1;
      samp_b   <= 1'b1;
      shreg    <= '0;
      pe_pend  <= 1'b0;
      fe_pend  <= 1'b0;
    end else begin
      if (start_det || tick) div_cnt <= '0;
      else                   div_cnt <= div_cnt + 1'b1;

      if (state == S_IDLE) begin
        tick_cnt <= '0;
        bit_cnt  <= '0;
        pe_pend  <= 1'b0;
        fe_pend  <= 1'b0;
      end else if (tick) begin
        tick_cnt <= at_end ? '0 : tick_cnt + 1'b1;
        if (tick_cnt == T_A) samp_a <= rx;
        if (tick_cnt == T_B) samp_b <= rx;
        if (at_c) begin
          unique case (state)
            S_DATA:  shreg   <= {maj, shreg[N_BITS-1:1]};
            S_PAR:   pe_pend <= par_bad;
            S_STOP:  if (!maj) fe_pend <= 1'b1;
            default: ;
          endcase
        end
        if (at_end) begin
          unique case (state)
            S_DATA:
              bit_cnt <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + 1'b1;
            S_STOP:  bit_cnt <= bit_cnt + 1'b1;
            default: ;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data       <= '0;
      valid      <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= done & valid & ~ready;
      if (load) begin
        data       <= shreg;
        parity_err <= pe_final;
        frame_err  <= fe_final;
        valid      <= 1'b1;
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_os.sv
// tb_uart_rx_os: scoreboard bench for uart_rx_os, one 8N1 receiver
// and one 8E1 receiver, 64 clocks per bit.
module tb_uart_rx_os;

  localparam int OS     = 16;
  localparam int BAUD   = 9600;
  localparam int CLK_HZ = BAUD * OS * 4;
  localparam int BIT    = 64;

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, enable;
  logic       rxd0, rxd1, ready0, ready1;
  logic [7:0] data0, data1;
  logic       valid0, valid1, pe0, pe1, fe0, fe1;
  logic       ov0, ov1, busy0, busy1;

  exp_t q0[$];
  exp_t q1[$];
  int   errors = 0;
  int   checks = 0;
  int   vcyc0  = 0;
  int   ovr0   = 0;

  uart_rx_os #(
    .BAUD_RATE(BAUD), .CLOCK_HZ(CLK_HZ), .N_BITS(8),
    .STOP_BITS(1), .PARITY(0), .OVERSAMPLE(OS)
  ) u_dut0 (
    .clk(clk), .reset(reset), .enable(enable), .rxd(rxd0),
    .data(data0), .valid(valid0), .ready(ready0),
    .parity_err(pe0), .frame_err(fe0), .overrun(ov0), .busy(busy0)
  );

  uart_rx_os #(
    .BAUD_RATE(BAUD), .CLOCK_HZ(CLK_HZ), .N_BITS(8),
    .STOP_BITS(1), .PARITY(2), .OVERSAMPLE(OS)
  ) u_dut1 (
    .clk(clk), .reset(reset), .enable(enable), .rxd(rxd1),
    .data(data1), .valid(valid1), .ready(ready1),
    .parity_err(pe1), .frame_err(fe1), .overrun(ov1), .busy(busy1)
  );

  function automatic exp_t mk(input logic [7:0] d,
                              input logic pe, input logic fe);
    return {d, pe, fe};
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic mon(input int ch, input exp_t got);
    exp_t e;
    checks++;
    if ((ch == 0 && q0.size() == 0) || (ch == 1 && q1.size() == 0)) begin
      errors++;
      $display("FAIL out%0d: got word %0h expected none", ch, got);
    end else begin
      e = (ch == 0) ? q0.pop_front() : q1.pop_front();
      if (got !== e) begin
        errors++;
        $display("FAIL out%0d: got d=%0h pe=%0b fe=%0b expected d=%0h pe=%0b fe=%0b",
                 ch, got.d, got.pe, got.fe, e.d, e.pe, e.fe);
      end
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (valid0) vcyc0++;
      if (ov0) ovr0++;
      if (valid0 && ready0) mon(0, {data0, pe0, fe0});
      if (valid1 && ready1) mon(1, {data1, pe1, fe1});
    end
  end

  task automatic line(input int ch, input logic v);
    if (ch == 0) rxd0 = v;
    else         rxd1 = v;
  endtask

  task automatic hold(input int ch, input logic v);
    line(ch, v);
    repeat (BIT) @(posedge clk);
    #1;
  endtask

  task automatic send(input int ch, input logic [7:0] d, input bit has_par,
                      input logic pbit, input logic stopv);
    hold(ch, 1'b0);
    for (int i = 0; i < 8; i++) hold(ch, d[i]);
    if (has_par) hold(ch, pbit);
    hold(ch, stopv);
    hold(ch, 1'b1);
  endtask

  initial begin
    reset  = 1'b1;
    enable = 1'b1;
    rxd0   = 1'b1;
    rxd1   = 1'b1;
    ready0 = 1'b1;
    ready1 = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("rst_valid0", valid0, 0);
    chk("rst_busy0", busy0, 0);
    chk("rst_data0", data0, 0);
    chk("rst_flags0", {pe0, fe0, ov0}, 0);
    chk("rst_valid1", valid1, 0);
    chk("rst_busy1", busy1, 0);
    reset = 1'b0;
    hold(0, 1'b1);
    hold(0, 1'b1);

    // 8N1 'V'
    q0.push_back(mk(8'h56, 1'b0, 1'b0));
    send(0, 8'h56, 0, 1'b0, 1'b1);
    chk("valid_one_cycle", vcyc0, 1);

    // short low glitch is a false start
    line(0, 1'b0);
    repeat (12) @(posedge clk);
    #1;
    line(0, 1'b1);
    chk("glitch_busy_hi", busy0, 1);
    repeat (48) @(posedge clk);
    #1;
    chk("glitch_busy_lo", busy0, 0);
    hold(0, 1'b1);
    chk("glitch_no_valid", vcyc0, 1);

    // even parity: 0x56 has four ones
    q1.push_back(mk(8'h56, 1'b1, 1'b0));
    send(1, 8'h56, 1, 1'b1, 1'b1);
    q1.push_back(mk(8'h56, 1'b0, 1'b0));
    send(1, 8'h56, 1, 1'b0, 1'b1);

    // low stop bit
    q0.push_back(mk(8'hA5, 1'b0, 1'b1));
    send(0, 8'hA5, 0, 1'b0, 1'b0);

    // overrun while held
    ready0 = 1'b0;
    q0.push_back(mk(8'h11, 1'b0, 1'b0));
    send(0, 8'h11, 0, 1'b0, 1'b1);
    send(0, 8'h22, 0, 1'b0, 1'b1);
    chk("ovr_pulses", ovr0, 1);
    chk("ovr_valid", valid0, 1);
    chk("ovr_data", data0, 8'h11);
    ready0 = 1'b1;
    @(posedge clk);
    #1;
    chk("ovr_valid_clr", valid0, 0);

    // reset during data bit 4
    hold(0, 1'b0);
    for (int i = 0; i < 4; i++) hold(0, 1'b0);
    line(0, 1'b1);
    repeat (32) @(posedge clk);
    #1;
    chk("midrst_busy_pre", busy0, 1);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("midrst_busy", busy0, 0);
    for (int i = 0; i < 6; i++) hold(0, 1'b1);
    q0.push_back(mk(8'h3C, 1'b0, 1'b0));
    send(0, 8'h3C, 0, 1'b0, 1'b1);

    // enable drop aborts a frame
    hold(1, 1'b0);
    hold(1, 1'b0);
    hold(1, 1'b0);
    chk("en_busy_pre", busy1, 1);
    enable = 1'b0;
    @(posedge clk);
    #1;
    chk("en_abort", busy1, 0);
    line(1, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    enable = 1'b1;
    for (int i = 0; i < 3; i++) hold(1, 1'b1);

    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
